reg_scoreboard: RTL
===================

# reg_scoreboard

Per-register pending-write tracker for the 8-entry, 16-bit register file. Decode issues destination registers, writeback retires them. The block stalls decode on RAW hazards against in-flight writes. It also generates the `dirty` write-protect flag consumed by the register-file write path, so that an older write is suppressed when a younger write to the same register is still outstanding.

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register pending counter; max pending writes per register = 2^CNT_W - 1.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `flush` input 1: synchronous clear of all pending state (pipeline flush).
- `iss_valid` input 1: decode requests to issue an instruction writing `iss_wreg`.
- `iss_wreg` input 3: destination register of the issuing instruction.
- `iss_ready` output 1: issue accepted this cycle when `iss_valid && iss_ready`.
- `use1`, `use2` input 1: decode actually reads `rreg1` / `rreg2`.
- `rreg1`, `rreg2` input 3: source registers being decoded.
- `stall` output 1: RAW hazard; decode must hold.
- `ret_valid` input 1: writeback retiring a write to `ret_wreg`.
- `ret_wreg` input 3: register being retired.
- `dirty` output 1: retiring write must not update the register file.
- `busy` output 8: bit i = register i has at least one pending write.
- `err` output 1: sticky; retire to a register with zero pending count.

## Operation
- State: eight CNT_W-bit counters `cnt[0..7]`, plus the `err` flop.
- Issue fires when `iss_valid && iss_ready`, and increments `cnt[iss_wreg]`.
- `iss_ready = !stall && (cnt[iss_wreg] != max)`. A saturated counter blocks issue; it never wraps.
- `stall = (use1 && cnt[rreg1] != 0) || (use2 && cnt[rreg2] != 0)`. This is combinational from the registered counters.
- Retire fires on `ret_valid` and decrements `cnt[ret_wreg]`. Retire is never back-pressured.
- Writes to the same register retire in program order. The design guarantees this; the block does not check it.
- `dirty = ret_valid && cnt[ret_wreg] > 1`: a younger write is still pending, so the older data is discarded (WAW protection).
- Retire with `cnt[ret_wreg] == 0`: the counter stays at 0, `dirty` = 0, and `err` sets on the next edge. `err` holds until `rst`.
- Simultaneous issue and retire, same register: the counter is unchanged. `dirty` is evaluated on the pre-update count.
- Simultaneous issue and retire, different registers: each counter updates independently.
- `flush`: all counters clear to 0 next edge. Issue and retire in the same cycle are ignored. `err` is unaffected.
- `rst` has priority over `flush`, issue and retire.
- `busy[i] = (cnt[i] != 0)`, registered view.

## Timing
- Reset values: all `cnt` = 0, `busy` = 8'h00, `err` = 0.
  - With inputs idle after reset: `stall` = 0, `iss_ready` = 1, `dirty` = 0.
- Issue in cycle N is visible in `busy`/`stall` from cycle N+1. There is no same-cycle self-hazard check; decode issues at most once per cycle.
- Retire in cycle N clears the hazard from cycle N+1. There is no bypass: a reader stalled in cycle N proceeds at N+1 at the earliest.
- `dirty`, `stall` and `iss_ready` are combinational, with zero latency from their inputs.
- A `rst` or `flush` asserted mid-operation takes effect at the next edge. Outstanding writes retiring afterward count as underflow, flag `err` and are not marked dirty.

## Test plan
- Reset, then idle: `busy`=00, `stall`=0, `iss_ready`=1, `err`=0.
- Issue r3 at cycle 1, then decode `rreg1`=3 with `use1`=1 at cycle 2 -> `stall`=1, `busy`=08. Retire r3 at cycle 4 -> `stall`=0 at cycle 5.
- Issue r5 twice, then retire r5 -> first retire `dirty`=1, second `dirty`=0. `busy[5]` clears after the second retire.
- Issue r2 three times (CNT_W=2) -> `iss_ready`=0 for `iss_wreg`=2. A simultaneous issue and retire of r2 at count 2 leaves the count at 2.
- Retire r7 with count 0 -> `err`=1 the next cycle and sticky through further traffic; cleared only by `rst`.
- Issue r1 and r4, then `flush` together with `ret_valid` on r1 -> `busy`=00 next cycle. A later retire of r1 sets `err`.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write tracker for an 8-entry register file.
// Decode issues destination registers and writeback retires them. Each
// register keeps a saturating count of in-flight writes. The count drives
// the RAW stall, the WAW write-protect flag (dirty), and the busy vector.
//
// Handshake: an issue is accepted on a cycle where iss_valid && iss_ready
// at the rising edge. Retire (ret_valid) is never back-pressured. stall,
// iss_ready and dirty are combinational from the registered counters.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       iss_valid,
  input  logic [2:0] iss_wreg,
  output logic       iss_ready,
  input  logic       use1,
  input  logic       use2,
  input  logic [2:0] rreg1,
  input  logic [2:0] rreg2,
  output logic       stall,
  input  logic       ret_valid,
  input  logic [2:0] ret_wreg,
  output logic       dirty,
  output logic [7:0] busy,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic             err_q;
  logic             err_d;
  logic             iss_fire;
  logic             ret_under;

  // Hazard, issue acceptance, write-protect and busy view from the counters
  always_comb begin
    stall     = (use1 && (cnt_q[rreg1] != '0)) || (use2 && (cnt_q[rreg2] != '0));
    iss_ready = !stall && (cnt_q[iss_wreg] != CNT_MAX);
    iss_fire  = iss_valid && iss_ready;
    // Older write is discarded when a younger write to the same reg is pending.
    dirty     = ret_valid && (cnt_q[ret_wreg] > CNT_ONE);
    ret_under = ret_valid && (cnt_q[ret_wreg] == '0);
    busy      = '0;
    for (int i = 0; i < 8; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
    err = err_q;
  end

  // Next-state counters: flush clears, issue increments, retire decrements
  always_comb begin
    logic inc;
    logic dec;
    err_d = err_q | (ret_under && !flush);
    for (int i = 0; i < 8; i++) begin
      inc      = iss_fire && (iss_wreg == 3'(i));
      // An underflowing retire leaves the counter at zero.
      dec      = ret_valid && (ret_wreg == 3'(i)) && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // State registers; rst dominates flush and all traffic
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

endmodule
